// File: rtl/req_encoder_16_to_4_pkg.sv
// Shared definitions for the 16-to-4 request encoder and its companion select decoder.
package req_encoder_16_to_4_pkg;

    localparam int unsigned REQ_N = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic logic [REQ_N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [REQ_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/req_encoder_16_to_4_if.sv
// Request collection and index handshake bundle; master is the encoder side.
interface req_encoder_16_to_4_if;
    import req_encoder_16_to_4_pkg::*;

    logic [REQ_N-1:0] req;
    logic             enable_bit;
    logic [IDX_W-1:0] out_index;
    logic             out_valid;
    logic             out_ready;
    logic [REQ_N-1:0] pending;
    logic             overrun;

    modport master (
        input  req, enable_bit, out_ready,
        output out_index, out_valid, pending, overrun
    );

    modport slave (
        output req, enable_bit, out_ready,
        input  out_index, out_valid, pending, overrun
    );

endinterface

// File: rtl/req_encoder_16_to_4_pick.sv
// Circular first-set-bit search over 16 lines, starting at a given index.
module pick_first_16
    import req_encoder_16_to_4_pkg::*;
(
    input  logic [REQ_N-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < REQ_N; k++) begin
            pos = start + IDX_W'(k);
            if (!found && vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder_16_to_4.sv
// Sticky pending register plus fixed/round-robin encoder presenting one index at a time.
module req_encoder_16_to_4
    import req_encoder_16_to_4_pkg::*;
#(
    parameter int unsigned RR_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    req_encoder_16_to_4_if.master bus
);

    state_t           state_q, state_d;
    logic [REQ_N-1:0] pending_q, pending_d, clr_mask;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, search_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             transfer;

    assign transfer  = out_valid_q & bus.out_ready;
    assign clr_mask  = transfer ? idx_to_onehot(out_index_q) : '0;
    // A request arriving in the clearing cycle re-sets the bit, so set wins over clear.
    assign pending_d = (pending_q & ~clr_mask) | bus.req;
    assign overrun_d = |(bus.req & pending_q & ~clr_mask);

    // The pointer takes the granted index in the same cycle so a back-to-back pick already skips it.
    assign rr_ptr_d     = transfer ? out_index_q : rr_ptr_q;
    assign search_start = (RR_MODE != 0) ? rr_ptr_d + IDX_W'(1) : '0;

    pick_first_16 u_pick (
        .vec   (pending_d),
        .start (search_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.enable_bit && pick_found) begin
                    out_index_d = pick_idx;
                    out_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (transfer) begin
                    if (bus.enable_bit && pick_found) begin
                        out_index_d = pick_idx;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            rr_ptr_q    <= '1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_index = out_index_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pending   = pending_q;
    assign bus.overrun   = overrun_q;

    offer_backed_by_pending: assert property (
        @(posedge clk) disable iff (!reset_n) out_valid_q |-> pending_q[out_index_q]
    );

endmodule

// File: tb/tb_req_encoder_16_to_4.sv
// Directed and random checks of the fixed-priority and round-robin encoder instances against a reference model.
module tb_req_encoder_16_to_4;

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    logic [15:0] cur_req;
    logic        cur_en, cur_rdy;

    // Reference model, index 0 = fixed priority, 1 = round-robin
    bit pm_pend [2][16];
    int pm_idx  [2];
    bit pm_vld  [2];
    bit pm_ovr  [2];
    int pm_ptr  [2];

    int          xcnt_f;
    logic [3:0]  last_f;

    req_encoder_16_to_4_if bf ();
    req_encoder_16_to_4_if br ();

    req_encoder_16_to_4 #(.RR_MODE(0)) dut_f (.clk(clk), .reset_n(reset_n), .bus(bf));
    req_encoder_16_to_4 #(.RR_MODE(1)) dut_r (.clk(clk), .reset_n(reset_n), .bus(br));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] r, input logic en, input logic rdy);
        cur_req = r; cur_en = en; cur_rdy = rdy;
        bf.req = r; bf.enable_bit = en; bf.out_ready = rdy;
        br.req = r; br.enable_bit = en; br.out_ready = rdy;
    endtask

    function automatic logic [15:0] model_vec(input int m);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = pm_pend[m][i];
        return v;
    endfunction

    function automatic bit model_empty();
        return model_vec(0) == 16'h0 && model_vec(1) == 16'h0 && !pm_vld[0] && !pm_vld[1];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) pm_pend[m][i] = 1'b0;
            pm_idx[m] = 0; pm_vld[m] = 1'b0; pm_ovr[m] = 1'b0; pm_ptr[m] = 15;
        end
    endtask

    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            bit np [16];
            bit xfer, clr, ov;
            int base, found;
            xfer = pm_vld[m] && cur_rdy;
            ov   = 1'b0;
            for (int i = 0; i < 16; i++) begin
                clr   = xfer && (pm_idx[m] == i);
                np[i] = (pm_pend[m][i] && !clr) || cur_req[i];
                if (cur_req[i] && pm_pend[m][i] && !clr) ov = 1'b1;
            end
            if (xfer) pm_ptr[m] = pm_idx[m];
            if (!pm_vld[m] || xfer) begin
                base  = (m == 1) ? pm_ptr[m] : 15;
                found = -1;
                for (int k = 1; k <= 16; k++)
                    if (found < 0 && np[(base + k) % 16]) found = (base + k) % 16;
                if (cur_en && found >= 0) begin
                    pm_idx[m] = found;
                    pm_vld[m] = 1'b1;
                end else begin
                    pm_vld[m] = 1'b0;
                end
            end
            for (int i = 0; i < 16; i++) pm_pend[m][i] = np[i];
            pm_ovr[m] = ov;
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [15:0] dp;
            logic        dv, dov;
            logic [3:0]  di;
            string       sfx;
            sfx = (m == 0) ? "_fix" : "_rr";
            if (m == 0) begin dp = bf.pending; dv = bf.out_valid; dov = bf.overrun; di = bf.out_index; end
            else        begin dp = br.pending; dv = br.out_valid; dov = br.overrun; di = br.out_index; end
            chk({"pending", sfx}, 32'(dp), 32'(model_vec(m)));
            chk({"out_valid", sfx}, 32'(dv), 32'(pm_vld[m]));
            chk({"overrun", sfx}, 32'(dov), 32'(pm_ovr[m]));
            if (pm_vld[m]) chk({"out_index", sfx}, 32'(di), pm_idx[m]);
        end
    endtask

    task automatic step();
        if (bf.out_valid && cur_rdy) begin
            xcnt_f++;
            last_f = bf.out_index;
        end
        model_clock();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        set_in(16'h0, 1'b1, 1'b1);
        for (int c = 0; c < 40; c++) begin
            if (model_empty()) break;
            step();
        end
        chk("drain_fix", {15'h0, bf.out_valid, bf.pending}, 32'h0);
        chk("drain_rr", {15'h0, br.out_valid, br.pending}, 32'h0);
    endtask

    task automatic check_reset();
        chk("rst_pending", {bf.pending, br.pending}, 32'h0);
        chk("rst_valid", {30'h0, bf.out_valid, br.out_valid}, 32'h0);
        chk("rst_overrun", {30'h0, bf.overrun, br.overrun}, 32'h0);
        chk("rst_index", {24'h0, bf.out_index, br.out_index}, 32'h0);
    endtask

    initial begin
        xcnt_f = 0;
        last_f = '0;
        reset_n = 1'b1;
        set_in(16'hFFFF, 1'b0, 1'b0);
        model_reset();

        // 1: reset held with all requests high
        #2 reset_n = 1'b0;
        #1 check_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_reset();
        end
        reset_n = 1'b1;
        step();
        chk("t1_pending_after_release", bf.pending, 16'hFFFF);
        drain();

        // 2: fixed priority over 8421
        set_in(16'h8421, 1'b1, 1'b1);
        step();
        chk("t2_idx0", {bf.out_valid, bf.out_index}, {1'b1, 4'd0});
        set_in(16'h0, 1'b1, 1'b1);
        step(); chk("t2_idx5", {bf.out_valid, bf.out_index}, {1'b1, 4'd5});
        step(); chk("t2_idx10", {bf.out_valid, bf.out_index}, {1'b1, 4'd10});
        step(); chk("t2_idx15", {bf.out_valid, bf.out_index}, {1'b1, 4'd15});
        step(); chk("t2_done", {bf.out_valid, bf.pending}, 17'h0);
        drain();

        // 3: backpressure
        set_in(16'h0010, 1'b1, 1'b0);
        step();
        set_in(16'h0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_hold", {bf.out_valid, bf.out_index}, {1'b1, 4'd4});
        end
        set_in(16'h0001, 1'b1, 1'b0);
        step();
        chk("t3_still4", {bf.out_valid, bf.out_index}, {1'b1, 4'd4});
        set_in(16'h0, 1'b1, 1'b1);
        step();
        chk("t3_next0", {bf.out_valid, bf.out_index}, {1'b1, 4'd0});
        drain();

        // reset while an offer is up
        set_in(16'h0060, 1'b1, 1'b0);
        step();
        chk("mid_offer_up", {bf.out_valid, bf.out_index}, {1'b1, 4'd5});
        set_in(16'h0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_reset();
        @(posedge clk); #1;
        check_reset();
        reset_n = 1'b1;

        // 4: round-robin alternation vs fixed priority
        set_in(16'h0003, 1'b1, 1'b1);
        step();
        chk("t4_first_fix", bf.out_index, 4'd0);
        chk("t4_first_rr", br.out_index, 4'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_fix", {bf.out_valid, bf.out_index}, {1'b1, 4'd0});
            chk("t4_rr", {br.out_valid, br.out_index}, {1'b1, (k % 2 == 0) ? 4'd1 : 4'd0});
        end
        drain();

        // 5: overrun and merge on bit 7
        set_in(16'h0080, 1'b1, 1'b0);
        step();
        set_in(16'h0, 1'b1, 1'b0);
        step();
        set_in(16'h0080, 1'b1, 1'b0);
        step();
        chk("t5_overrun", bf.overrun, 1'b1);
        set_in(16'h0, 1'b1, 1'b0);
        step();
        chk("t5_overrun_pulse", bf.overrun, 1'b0);
        xcnt_f = 0;
        set_in(16'h0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) step();
        chk("t5_one_transfer", xcnt_f, 1);
        chk("t5_transfer_idx", last_f, 4'd7);
        set_in(16'h0080, 1'b1, 1'b0);
        step();
        set_in(16'h0080, 1'b1, 1'b1);
        step();
        chk("t5_set_wins", bf.pending[7], 1'b1);
        chk("t5_no_overrun", bf.overrun, 1'b0);
        drain();

        // 6: enable gating
        set_in(16'h0100, 1'b0, 1'b0);
        step();
        chk("t6_no_valid", {bf.out_valid, bf.pending}, {1'b0, 16'h0100});
        set_in(16'h0, 1'b0, 1'b0);
        step();
        set_in(16'h0, 1'b1, 1'b0);
        step();
        chk("t6_valid8", {bf.out_valid, bf.out_index}, {1'b1, 4'd8});
        set_in(16'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_held", {bf.out_valid, bf.out_index}, {1'b1, 4'd8});
        end
        set_in(16'h0, 1'b0, 1'b1);
        step();
        chk("t6_released", {bf.out_valid, bf.pending}, 17'h0);
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 2) == 0) r = '0;
            set_in(r, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
